uart_receiver: RTL and testbench

- UART receive path for the rx_tx controller. It takes an asynchronous serial line and recovers frames using a 16x oversampling enable derived from clk_in by a runtime divide factor.
- Frame format: 1 start bit, DATA_BITS data bits LSB first, optional parity, 1 stop bit.
- Received bytes go to a single-entry holding register with a valid/ready handshake. Framing, parity and overrun errors are flagged.
- This is the counterpart of the transmitter; both share the same divide-factor programming model.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_tick_gen.sv | 28 ++
 rtl/uart_receiver.sv | 180 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and the
// parity helper used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Parity bit that makes the frame even (odd=0) or odd (odd=1); unused upper bits must be 0.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample clock-enable generator: one-cycle tick every div_factor cycles (0/1 -> every cycle).
// Counter is held at 0 while disabled so the first tick lands a full period after enable rises.
module uart_rx_tick_gen (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] div_factor,
  input  logic        enable,
  output logic        tick
);

  logic [31:0] cnt;
  logic [31:0] term;

  // >= rather than == so a mid-count decrease of div_factor wraps instead of running 2^32 cycles
  assign term = (div_factor <= 32'd1) ? 32'd0 : div_factor - 32'd1;
  assign tick = enable && (cnt >= term);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised rx, 16x-style oversampled framing, single-entry holding register.
// rx_valid rises ~2 sync + 1 detect + 9.5 bit periods after the start edge; a full register that is not drained drops the new frame (overrun).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [31:0]          div_factor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  rx_state_t            state, state_nxt;
  logic [SC_W-1:0]      sc, sc_nxt;
  logic [BC_W-1:0]      bc, bc_nxt;
  logic                 rx_meta, rxs;
  logic                 tick;
  logic                 shift_en, par_cap, commit_set, frame_set;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q, commit_q, par_bad;
  logic [7:0]           data8;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  uart_rx_tick_gen u_tick (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_factor (div_factor),
    .enable     (state != IDLE),
    .tick       (tick)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
    end else begin
      state <= state_nxt;
      sc    <= sc_nxt;
      bc    <= bc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sc_nxt     = sc;
    bc_nxt     = bc;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    commit_set = 1'b0;
    frame_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          sc_nxt    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sc == SC_HALF) begin
            sc_nxt    = '0;
            bc_nxt    = '0;
            state_nxt = rxs ? IDLE : DATA;
          end else begin
            sc_nxt = sc + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            sc_nxt   = '0;
            shift_en = 1'b1;
            if (bc == BC_LAST) begin
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bc_nxt = bc + 1'b1;
            end
          end else begin
            sc_nxt = sc + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            sc_nxt    = '0;
            par_cap   = 1'b1;
            state_nxt = STOP;
          end else begin
            sc_nxt = sc + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sc == SC_LAST) begin
            sc_nxt = '0;
            if (rxs) begin
              commit_set = 1'b1;
              state_nxt  = IDLE;
            end else begin
              frame_set = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            sc_nxt = sc + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data8   = 8'(shreg);
  assign par_bad = (PARITY_EN != 0) && (par_q != parity_bit(data8, PARITY_ODD != 0));
  assign busy    = (state != IDLE);

  // shreg and par_q stay stable through the commit cycle: nothing shifts until the next DATA state
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      par_q      <= 1'b0;
      commit_q   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      commit_q   <= commit_set;
      frame_err  <= frame_set;
      parity_err <= commit_q && par_bad;
      overrun    <= 1'b0;
      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      if (par_cap) par_q <= rxs;
      if (commit_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed table, hand-written corner sequences and randomized frames
// on a no-parity instance (dut0) and an even-parity instance (dut1).
module tb_uart_receiver;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] div_factor = 32'd4;
  logic        rx0 = 1'b1, rx1 = 1'b1, ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0]  data0, data1;
  logic        valid0, valid1, ferr0, ferr1, perr0, perr1, ovr0, ovr1, busy0, busy1;

  always #5 clk_in = ~clk_in;

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16)) dut0 (
    .clk_in(clk_in), .reset(reset), .div_factor(div_factor), .rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0), .frame_err(ferr0),
    .parity_err(perr0), .overrun(ovr0), .busy(busy0)
  );

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(16)) dut1 (
    .clk_in(clk_in), .reset(reset), .div_factor(div_factor), .rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1), .frame_err(ferr1),
    .parity_err(perr1), .overrun(ovr1), .busy(busy1)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  logic [7:0] acc0[$], acc1[$];
  int nferr0 = 0, nferr1 = 0, nperr0 = 0, nperr1 = 0, novr0 = 0, novr1 = 0;
  int rise0 = 0;
  logic valid0_d = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (valid0 && ready0) acc0.push_back(data0);
    if (valid1 && ready1) acc1.push_back(data1);
    if (ferr0) nferr0 <= nferr0 + 1;
    if (ferr1) nferr1 <= nferr1 + 1;
    if (perr0) nperr0 <= nperr0 + 1;
    if (perr1) nperr1 <= nperr1 + 1;
    if (ovr0) novr0 <= novr0 + 1;
    if (ovr1) novr1 <= novr1 + 1;
    if (valid0 && !valid0_d) rise0 <= cyc;
    valid0_d <= valid0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Drives the first nper bit periods of a frame; line is left at the last bit driven.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic par, input logic stop,
                            input int bitc, input int nper);
    logic b[12];
    int   n;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    n = 9;
    if (sel == 1) begin
      b[n] = par;
      n++;
    end
    b[n] = stop;
    n++;
    if (nper < n) n = nper;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx0 = b[i];
      else rx1 = b[i];
      repeat (bitc) @(posedge clk_in);
      #1;
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         exp_acc;
    logic [7:0] exp_d;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t       tbl[9];
  logic [7:0] exp0[$], exp1[$];

  initial begin
    int c0, lat, na, nf, np, no, base, nbad, dv, bitc;
    logic [7:0] d, lastd;
    logic st, par;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 0, 0};
    tbl[1] = '{0, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 1, 0};
    tbl[2] = '{1, 8'h07, 1'b0, 1'b1, 1, 8'h07, 0, 1};
    tbl[3] = '{1, 8'h07, 1'b1, 1'b1, 1, 8'h07, 0, 0};
    tbl[4] = '{1, 8'h00, 1'b0, 1'b1, 1, 8'h00, 0, 0};
    tbl[5] = '{1, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 0, 0};
    tbl[6] = '{1, 8'h80, 1'b0, 1'b1, 1, 8'h80, 0, 1};
    tbl[7] = '{0, 8'h00, 1'b0, 1'b1, 1, 8'h00, 0, 0};
    tbl[8] = '{0, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 0, 0};

    idle(3);
    check("reset_valid0", 32'(valid0), 32'd0);
    check("reset_data0", 32'(data0), 32'd0);
    check("reset_busy0", 32'(busy0), 32'd0);
    check("reset_errs0", 32'({ferr0, perr0, ovr0}), 32'd0);
    check("reset_valid1", 32'(valid1), 32'd0);
    reset = 1'b0;
    idle(5);

    // first-frame latency and data
    na = acc0.size(); nf = nferr0; no = novr0;
    c0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 64, 10);
    idle(10);
    lat = rise0 - c0;
    total++;
    if (lat < 609 || lat > 613) begin
      bad++;
      $display("FAIL latency: got %0d want 609..613", lat);
    end
    check("a5_count", 32'(acc0.size() - na), 32'd1);
    if (acc0.size() > na) check("a5_data", 32'(acc0[$]), 32'hA5);
    check("a5_flags", 32'((nferr0 - nf) + (novr0 - no)), 32'd0);

    // glitch shorter than half a bit
    na = acc0.size(); nf = nferr0;
    rx0 = 1'b0;
    idle(20);
    check("glitch_busy", 32'(busy0), 32'd1);
    rx0 = 1'b1;
    idle(60);
    check("glitch_idle", 32'(busy0), 32'd0);
    check("glitch_nodata", 32'(acc0.size() - na), 32'd0);
    check("glitch_noferr", 32'(nferr0 - nf), 32'd0);

    // framing error followed by a held-low line
    na = acc0.size(); nf = nferr0;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 64, 10);
    idle(3 * 64);
    check("break_busy", 32'(busy0), 32'd1);
    check("break_ferr", 32'(nferr0 - nf), 32'd1);
    rx0 = 1'b1;
    idle(20);
    check("break_idle", 32'(busy0), 32'd0);
    check("break_ferr_once", 32'(nferr0 - nf), 32'd1);
    check("break_nodata", 32'(acc0.size() - na), 32'd0);

    // directed table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].sel == 0) begin na = acc0.size(); nf = nferr0; np = nperr0; end
      else begin na = acc1.size(); nf = nferr1; np = nperr1; end
      send_frame(tbl[i].sel, tbl[i].d, tbl[i].par, tbl[i].stop, 64, 11);
      rx0 = 1'b1; rx1 = 1'b1;
      idle(40);
      if (tbl[i].sel == 0) begin
        check($sformatf("tbl%0d_count", i), 32'(acc0.size() - na), 32'(tbl[i].exp_acc));
        check($sformatf("tbl%0d_ferr", i), 32'(nferr0 - nf), 32'(tbl[i].exp_ferr));
        check($sformatf("tbl%0d_perr", i), 32'(nperr0 - np), 32'(tbl[i].exp_perr));
        lastd = (acc0.size() > 0) ? acc0[$] : 8'h00;
      end else begin
        check($sformatf("tbl%0d_count", i), 32'(acc1.size() - na), 32'(tbl[i].exp_acc));
        check($sformatf("tbl%0d_ferr", i), 32'(nferr1 - nf), 32'(tbl[i].exp_ferr));
        check($sformatf("tbl%0d_perr", i), 32'(nperr1 - np), 32'(tbl[i].exp_perr));
        lastd = (acc1.size() > 0) ? acc1[$] : 8'h00;
      end
      if (tbl[i].exp_acc == 1) check($sformatf("tbl%0d_data", i), 32'(lastd), 32'(tbl[i].exp_d));
    end

    // overrun: two back-to-back frames into an undrained register
    ready0 = 1'b0;
    no = novr0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 64, 10);
    send_frame(0, 8'h22, 1'b0, 1'b1, 64, 10);
    idle(10);
    check("ovr_valid", 32'(valid0), 32'd1);
    check("ovr_data_held", 32'(data0), 32'h11);
    check("ovr_pulse", 32'(novr0 - no), 32'd1);
    ready0 = 1'b1;
    idle(1);
    check("ovr_drained", 32'(valid0), 32'd0);
    check("ovr_drained_data", 32'(acc0[$]), 32'h11);

    // accept exactly on the second commit cycle
    ready0 = 1'b0;
    no = novr0;
    fork
      begin
        send_frame(0, 8'h11, 1'b0, 1'b1, 64, 10);
        send_frame(0, 8'h22, 1'b0, 1'b1, 64, 10);
      end
      begin
        repeat (640 + 611) @(posedge clk_in);
        #1 ready0 = 1'b1;
        @(posedge clk_in);
        #1 ready0 = 1'b0;
      end
    join
    idle(10);
    check("sim_data", 32'(data0), 32'h22);
    check("sim_valid", 32'(valid0), 32'd1);
    check("sim_no_ovr", 32'(novr0 - no), 32'd0);
    check("sim_acc_first", 32'(acc0[$]), 32'h11);
    ready0 = 1'b1;
    idle(2);
    check("sim_acc_second", 32'(acc0[$]), 32'h22);

    // reset in the middle of a frame while the register is full
    ready0 = 1'b0;
    send_frame(0, 8'h99, 1'b0, 1'b1, 64, 10);
    idle(5);
    check("pre_reset_valid", 32'(valid0), 32'd1);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 64, 5);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(valid0), 32'd0);
    check("arst_data", 32'(data0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    rx0 = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    ready0 = 1'b1;
    na = acc0.size();
    send_frame(0, 8'hC3, 1'b0, 1'b1, 64, 10);
    idle(20);
    check("post_reset_count", 32'(acc0.size() - na), 32'd1);
    if (acc0.size() > na) check("post_reset_data", 32'(acc0[$]), 32'hC3);

    // randomized frames on dut0 with random stop-bit validity and divide factor
    base = acc0.size(); nf = nferr0; nbad = 0;
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) != 0);
      dv = $urandom_range(0, 4);
      div_factor = 32'(dv);
      bitc = 16 * ((dv <= 1) ? 1 : dv);
      idle(2);
      send_frame(0, d, 1'b0, st, bitc, 10);
      rx0 = 1'b1;
      idle($urandom_range(4, 40));
      if (st) exp0.push_back(d);
      else nbad++;
    end
    idle(50);
    check("rnd0_count", 32'(acc0.size() - base), 32'(exp0.size()));
    check("rnd0_ferr", 32'(nferr0 - nf), 32'(nbad));
    for (int i = 0; i < exp0.size(); i++)
      if (base + i < acc0.size()) check($sformatf("rnd0_data%0d", i), 32'(acc0[base+i]), 32'(exp0[i]));

    // randomized parity frames on dut1: error whenever data+parity has an odd number of ones
    base = acc1.size(); np = nperr1; nbad = 0;
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom_range(0, 255));
      par = 1'($urandom_range(0, 1));
      dv  = $urandom_range(0, 4);
      div_factor = 32'(dv);
      bitc = 16 * ((dv <= 1) ? 1 : dv);
      idle(2);
      send_frame(1, d, par, 1'b1, bitc, 11);
      rx1 = 1'b1;
      idle($urandom_range(4, 40));
      exp1.push_back(d);
      if ((($countones(d) + int'(par)) % 2) != 0) nbad++;
    end
    idle(50);
    check("rnd1_count", 32'(acc1.size() - base), 32'(exp1.size()));
    check("rnd1_perr", 32'(nperr1 - np), 32'(nbad));
    for (int i = 0; i < exp1.size(); i++)
      if (base + i < acc1.size()) check($sformatf("rnd1_data%0d", i), 32'(acc1[base+i]), 32'(exp1[i]));

    check("noparity_never_perr", 32'(nperr0), 32'd0);
    check("dut1_no_ovr", 32'(novr1), 32'd0);
    check("dut1_no_ferr", 32'(nferr1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
